// File: rtl/reg_xfer_seq_pkg.sv
// ============================================================================
// Module      : reg_xfer_seq_pkg
// Description : Shared op codes, bus select codes, FSM state encoding and
//               micro-op table for the register transfer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_xfer_seq_pkg;

  // Operation codes
  localparam logic [1:0] OP_COPY_AB = 2'd0;
  localparam logic [1:0] OP_COPY_BA = 2'd1;
  localparam logic [1:0] OP_SWAP_AB = 2'd2;
  localparam logic [1:0] OP_CLEAR   = 2'd3;

  // Bus mux select codes
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One micro-op: bus source plus the register strobes fired from it
  typedef struct packed {
    logic [1:0] sel;
    logic       load_a;
    logic       load_b;
    logic       load_c;
  } uop_t;

  localparam uop_t UOP_COPY_AB = '{sel: SEL_A,    load_a: 1'b0, load_b: 1'b1, load_c: 1'b0};
  localparam uop_t UOP_COPY_BA = '{sel: SEL_B,    load_a: 1'b1, load_b: 1'b0, load_c: 1'b0};
  localparam uop_t UOP_SWAP_0  = '{sel: SEL_A,    load_a: 1'b0, load_b: 1'b0, load_c: 1'b1};
  localparam uop_t UOP_SWAP_1  = '{sel: SEL_B,    load_a: 1'b1, load_b: 1'b0, load_c: 1'b0};
  localparam uop_t UOP_SWAP_2  = '{sel: SEL_C,    load_a: 1'b0, load_b: 1'b1, load_c: 1'b0};
  localparam uop_t UOP_CLEAR   = '{sel: SEL_ZERO, load_a: 1'b1, load_b: 1'b1, load_c: 1'b1};

  // Micro-op table lookup by operation and micro-op index
  function automatic uop_t uop_lookup(input logic [1:0] op, input logic [1:0] idx);
    uop_t u;
    case (op)
      OP_COPY_AB: u = UOP_COPY_AB;
      OP_COPY_BA: u = UOP_COPY_BA;
      OP_SWAP_AB: begin
        case (idx)
          2'd0:    u = UOP_SWAP_0;
          2'd1:    u = UOP_SWAP_1;
          default: u = UOP_SWAP_2;
        endcase
      end
      default:    u = UOP_CLEAR;
    endcase
    return u;
  endfunction

  // Index of the final micro-op of an operation
  function automatic logic [1:0] uop_last(input logic [1:0] op);
    return (op == OP_SWAP_AB) ? 2'd2 : 2'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xfer_edge_det.sv
// ============================================================================
// Module      : xfer_edge_det
// Description : Registered rising-edge detector. History resets to 1 so a
//               level already high when reset releases is not seen as an edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xfer_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_hist;
  logic r_rise;

  // Track previous level and register a one-cycle pulse on 0->1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_hist <= d;
      r_rise <= d & ~r_hist;
    end
  end

  assign rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/reg_xfer_seq.sv
// ============================================================================
// Module      : reg_xfer_seq
// Description : Micro-sequenced register transfer controller. Steps through a
//               per-operation micro-op table, driving the bus select, waiting
//               SETTLE cycles, then pulsing the register load strobes.
//               Optional macro XFER_STEP_EN: each micro-op additionally waits
//               for a rising edge on step once the settle time has expired.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_xfer_seq
  import reg_xfer_seq_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       step,
  output logic [1:0] sel,
  output logic       xfer_mode,
  output logic       load_a,
  output logic       load_b,
  output logic       load_c,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] C_SETTLE_M1 = 4'(SETTLE - 1);

  state_t     r_state;
  logic [1:0] r_op;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic       r_load_a;
  logic       r_load_b;
  logic       r_load_c;
  logic       r_busy;
  logic       r_done;
  logic       r_xfer;

  logic       w_start_rise;
  logic       w_advance;
  logic [1:0] w_lk_op;
  logic [1:0] w_lk_idx;
  uop_t       w_uop;

  xfer_edge_det u_start_det (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (w_start_rise)
  );

`ifdef XFER_STEP_EN
  logic w_step_rise;

  xfer_edge_det u_step_det (
    .clk  (clk),
    .rst  (rst),
    .d    (step),
    .rise (w_step_rise)
  );

  assign w_advance = w_step_rise;
`else
  logic unused_step;

  assign unused_step = step;
  assign w_advance   = 1'b1;
`endif

  // Single table lookup: first micro-op of the incoming op while idle,
  // the following micro-op in NEXT, the current one otherwise
  always_comb begin
    w_lk_op  = r_op;
    w_lk_idx = r_idx;
    if (r_state == ST_IDLE) begin
      w_lk_op  = op;
      w_lk_idx = 2'd0;
    end else if (r_state == ST_NEXT) begin
      w_lk_idx = r_idx + 2'd1;
    end
    w_uop = uop_lookup(w_lk_op, w_lk_idx);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_COPY_AB;
      r_idx    <= 2'd0;
      r_cnt    <= 4'd0;
      r_sel    <= SEL_ZERO;
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
      r_load_c <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_xfer   <= 1'b0;
    end else begin
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
      r_load_c <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_rise) begin
            r_op    <= op;
            r_idx   <= 2'd0;
            r_cnt   <= C_SETTLE_M1;
            r_sel   <= w_uop.sel;
            r_busy  <= 1'b1;
            r_xfer  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (w_advance) begin
            r_sel    <= w_uop.sel;
            r_load_a <= w_uop.load_a;
            r_load_b <= w_uop.load_b;
            r_load_c <= w_uop.load_c;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx != uop_last(r_op)) begin
            r_idx   <= r_idx + 2'd1;
            r_cnt   <= C_SETTLE_M1;
            r_sel   <= w_uop.sel;
            r_state <= ST_SETUP;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_xfer  <= 1'b0;
          r_sel   <= SEL_ZERO;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign xfer_mode = r_xfer;
  assign load_a    = r_load_a;
  assign load_b    = r_load_b;
  assign load_c    = r_load_c;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_xfer_seq.sv
// ============================================================================
// Module      : tb_reg_xfer_seq
// Description : Scoreboard bench for reg_xfer_seq with an emulated A/B/C
//               datapath driven by the sequencer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_xfer_seq;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step;
  logic [1:0] op;
  logic [1:0] sel;
  logic       xfer_mode, load_a, load_b, load_c, busy, done;

  always #5 clk = ~clk;

  reg_xfer_seq #(.SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .step      (step),
    .sel       (sel),
    .xfer_mode (xfer_mode),
    .load_a    (load_a),
    .load_b    (load_b),
    .load_c    (load_c),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    bit         is_done;
    logic [1:0] sel;
    logic [2:0] loads;   // {a,b,c}
    int         t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  int   n_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Emulated datapath: registers take the bus on their strobe when xfer_mode
  logic [7:0] ra, rb, rc, bus;
  logic [7:0] set_a, set_b, set_c;
  bit         dp_set = 1'b0;

  always @(posedge clk) begin
    if (dp_set) begin
      ra <= set_a; rb <= set_b; rc <= set_c;
    end else if (xfer_mode) begin
      case (sel)
        2'd0:    bus = ra;
        2'd1:    bus = rb;
        2'd2:    bus = rc;
        default: bus = 8'd0;
      endcase
      if (load_a) ra <= bus;
      if (load_b) rb <= bus;
      if (load_c) rc <= bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Micro-op table straight from the operation definitions: loads = {a,b,c}
  function automatic void exp_uop(input logic [1:0] o, input int i,
                                  output logic [1:0] s, output logic [2:0] l);
    case (o)
      2'd0: begin s = 2'd0; l = 3'b010; end
      2'd1: begin s = 2'd1; l = 3'b100; end
      2'd2: begin
        if (i == 0)      begin s = 2'd0; l = 3'b001; end
        else if (i == 1) begin s = 2'd1; l = 3'b100; end
        else             begin s = 2'd2; l = 3'b010; end
      end
      default: begin s = 2'd3; l = 3'b111; end
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a strobe or done appears
  always @(negedge clk) begin
    if (mon_en) begin
`ifndef XFER_STEP_EN
      while (q.size() > 0 && q[0].t < cyc) begin
        tests++; fails++;
        $display("FAIL missing_event: expected at cycle %0d, still absent at cycle %0d", q[0].t, cyc);
        void'(q.pop_front());
      end
`endif
      if (load_a || load_b || load_c || done) begin
        if (!done) n_strobe++;
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: loads=%b done=%b sel=%0d at cycle %0d, required none",
                   {load_a, load_b, load_c}, done, sel, cyc);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(done), 32'(e.is_done));
          if (!e.is_done) begin
            chk("strobe_sel", 32'(sel), 32'(e.sel));
            chk("strobe_set", 32'({load_a, load_b, load_c}), 32'(e.loads));
          end else begin
            chk("done_no_strobe", 32'({load_a, load_b, load_c}), 32'd0);
          end
`ifndef XFER_STEP_EN
          chk("event_cycle", 32'(cyc), 32'(e.t));
`endif
        end
      end
`ifndef XFER_STEP_EN
      begin
        bit expb;
        expb = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("busy", 32'(busy), 32'(expb));
        chk("xfer_mode", 32'(xfer_mode), 32'(expb));
        if (!expb) chk("idle_sel", 32'(sel), 32'd3);
      end
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issue one operation; hold = cycles start stays high, reedge = pulse a
  // second start edge mid-operation, do_rst = reset just before 2nd micro-op
  task automatic run_op(input logic [1:0] o, input int hold, input bit reedge, input bit do_rst);
    logic [7:0] a0, b0, c0, ea, eb, ec;
    logic [1:0] s;
    logic [2:0] l;
    int k, n, total, rst_cyc, strobes0;
    bit rst_done;
    a0 = 8'($urandom); b0 = 8'($urandom); c0 = 8'($urandom);
    set_a = a0; set_b = b0; set_c = c0; dp_set = 1'b1;
    tick();
    dp_set = 1'b0;
    op = o; start = 1'b1; k = cyc;
    n = (o == 2'd2) ? 3 : 1;
    for (int i = 0; i < n; i++) begin
      exp_uop(o, i, s, l);
      q.push_back('{1'b0, s, l, k + 1 + i * (SETTLE + 2) + SETTLE + 1});
    end
    q.push_back('{1'b1, 2'd0, 3'b000, k + 2 + n * (SETTLE + 2)});
    busy_lo = k + 2;
    busy_hi = k + 2 + n * (SETTLE + 2);
    case (o)
      2'd0:    begin ea = a0; eb = a0; ec = c0; end
      2'd1:    begin ea = b0; eb = b0; ec = c0; end
      2'd2:    begin ea = b0; eb = a0; ec = a0; end
      default: begin ea = 8'd0; eb = 8'd0; ec = 8'd0; end
    endcase
    rst_cyc  = k + 1 + (SETTLE + 2) + SETTLE;
    rst_done = 1'b0;
    strobes0 = n_strobe;
`ifdef XFER_STEP_EN
    total = n * (SETTLE + 4) + 40;
`else
    total = n * (SETTLE + 2) + 8;
`endif
    if (total < hold + 3) total = hold + 3;
    for (int c = 1; c <= total; c++) begin
      tick();
      if (rst) rst = 1'b0;
      if (c == hold) start = 1'b0;
      if (reedge && c == 4) start = 1'b0;
      if (reedge && c == 5) start = 1'b1;
      if (do_rst && !rst_done && cyc == rst_cyc) begin
        rst = 1'b1; rst_done = 1'b1;
        q.delete();
        busy_hi = cyc;
      end
`ifdef XFER_STEP_EN
      if (c == 19) chk("no_strobe_without_step", 32'(n_strobe), 32'(strobes0));
      step = (c >= 20) && ((c % (SETTLE + 4)) == 0);
`endif
    end
    start = 1'b0; step = 1'b0;
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    if (do_rst) begin
      ea = a0; eb = b0; ec = a0;
    end
    chk("reg_a", 32'(ra), 32'(ea));
    chk("reg_b", 32'(rb), 32'(eb));
    chk("reg_c", 32'(rc), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; step = 1'b0; op = 2'd0;
    repeat (3) @(posedge clk);
    tick();
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xfer_mode", 32'(xfer_mode), 32'd0);
    chk("rst_strobes", 32'({load_a, load_b, load_c}), 32'd0);
    mon_en = 1'b1;
    // start still high as reset releases: must not trigger
    rst = 1'b0;
    repeat (10) tick();
    start = 1'b0;
    tick();

    run_op(2'd0, 1, 1'b0, 1'b0);
    run_op(2'd2, 1, 1'b0, 1'b0);
    run_op(2'd3, 1, 1'b0, 1'b0);
    run_op(2'd1, 1, 1'b0, 1'b0);
    run_op(2'd0, 50, 1'b0, 1'b0);
    run_op(2'd2, 10, 1'b1, 1'b0);
`ifndef XFER_STEP_EN
    run_op(2'd2, 1, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 20; i++) begin
      run_op(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
